// File: rtl/core_en_sequencer.sv
// -----------------------------------------------------------------------------
// core_en_sequencer
//
// Drives the core enable consumed by the per-core clock-gate/reset controller.
// Power-up: raise enable, wait for the controller to release core reset.
// Shutdown: handshake a quiesce with the core, drop enable, then hold enable
// low for a minimum off time (and until reset is seen asserted again) before
// a new start is accepted.
//
// Optional feature (macro CORE_SEQ_TIMEOUT_EN):
//   When defined, POWERUP and QUIESCE are guarded by a watchdog of
//   TIMEOUT_CYCLES cycles. Expiry forces DRAIN and sets the sticky
//   err_timeout_o, which is cleared by the next accepted start.
//   When undefined, both states wait indefinitely and err_timeout_o is 0.
//
// Ports:
//   clk_i            in   clock
//   reset_n_i        in   asynchronous active-low reset
//   start_i          in   1-cycle start request (honoured only in OFF)
//   stop_i           in   1-cycle stop request (honoured only in POWERUP/RUN)
//   core_rst_n_fb_i  in   core reset_n feedback, asynchronous, synced here
//   quiesce_ack_i    in   core idle acknowledge, level
//   core_en_o        out  core enable, registered
//   quiesce_req_o    out  drain/idle request to the core, registered
//   running_o        out  state is RUN
//   busy_o           out  state is POWERUP, QUIESCE or DRAIN
//   err_timeout_o    out  sticky watchdog error
//   state_o          out  OFF=0 POWERUP=1 RUN=2 QUIESCE=3 DRAIN=4
// -----------------------------------------------------------------------------
module core_en_sequencer #(
    parameter int CNT_W          = 16,
    parameter int OFF_MIN_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       core_rst_n_fb_i,
    input  logic       quiesce_ack_i,
    output logic       core_en_o,
    output logic       quiesce_req_o,
    output logic       running_o,
    output logic       busy_o,
    output logic       err_timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_POWERUP = 3'd1,
        ST_RUN     = 3'd2,
        ST_QUIESCE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_fb_meta;
    logic             r_fb_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic             w_wd_expired;
    logic             w_wd_load;
    logic             w_start_ok;
    logic             w_timeout_hit;
    logic             r_core_en;
    logic             r_quiesce_req;
    logic             r_running;
    logic             r_busy;
    logic             r_err_timeout;

    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

`ifdef CORE_SEQ_TIMEOUT_EN
    // Watchdog armed on every entry into a waiting state.
    assign w_wd_load    = (w_state_nxt != r_state) &&
                          ((w_state_nxt == ST_POWERUP) || (w_state_nxt == ST_QUIESCE));
    assign w_wd_expired = w_cnt_zero;
`else
    assign w_wd_load    = 1'b0;
    assign w_wd_expired = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous core reset feedback.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fb_meta <= 1'b0;
            r_fb_sync <= 1'b0;
        end else begin
            r_fb_meta <= core_rst_n_fb_i;
            r_fb_sync <= r_fb_meta;
        end
    end

    // Next-state decode; requests arriving in states that do not honour them are dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_ok    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_OFF: begin
                // A simultaneous stop cancels the start.
                if (start_i && !stop_i) begin
                    w_state_nxt = ST_POWERUP;
                    w_start_ok  = 1'b1;
                end else begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_POWERUP: begin
                // Core never left reset, so no quiesce handshake is needed on stop.
                if (stop_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_fb_sync) begin
                    w_state_nxt = ST_RUN;
                end else if (w_wd_expired) begin
                    w_state_nxt   = ST_DRAIN;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_state_nxt = ST_POWERUP;
                end
            end
            ST_RUN: begin
                // Losing reset release means the core is already gone: skip quiesce.
                if (!r_fb_sync) begin
                    w_state_nxt = ST_DRAIN;
                end else if (stop_i) begin
                    w_state_nxt = ST_QUIESCE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_QUIESCE: begin
                if (quiesce_ack_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_wd_expired) begin
                    w_state_nxt   = ST_DRAIN;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_state_nxt = ST_QUIESCE;
                end
            end
            ST_DRAIN: begin
                // Leave only after the off time has elapsed and the core is back in reset.
                if (w_cnt_zero && !r_fb_sync) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Counter: loaded on state entry, otherwise counts down and holds at zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if ((w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN)) begin
            w_cnt_nxt = OFF_LOAD;
        end else if (w_wd_load) begin
            w_cnt_nxt = WD_LOAD;
        end else if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State, counter, and output flops; outputs are decoded from the next state
    // so they change in the same cycle the state does.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= ST_OFF;
            r_cnt         <= {CNT_W{1'b0}};
            r_core_en     <= 1'b0;
            r_quiesce_req <= 1'b0;
            r_running     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_core_en     <= (w_state_nxt == ST_POWERUP) || (w_state_nxt == ST_RUN) ||
                             (w_state_nxt == ST_QUIESCE);
            r_quiesce_req <= (w_state_nxt == ST_QUIESCE);
            r_running     <= (w_state_nxt == ST_RUN);
            r_busy        <= (w_state_nxt == ST_POWERUP) || (w_state_nxt == ST_QUIESCE) ||
                             (w_state_nxt == ST_DRAIN);
            if (w_start_ok) begin
                r_err_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end else begin
                r_err_timeout <= r_err_timeout;
            end
        end
    end

    assign core_en_o     = r_core_en;
    assign quiesce_req_o = r_quiesce_req;
    assign running_o     = r_running;
    assign busy_o        = r_busy;
    assign err_timeout_o = r_err_timeout;
    assign state_o       = r_state;

endmodule

// File: tb/tb_core_en_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_en_sequencer
//
// Table-driven bench with a scoreboard queue: each step drives one cycle of
// inputs and pushes the outputs expected after the next rising edge; the
// value is popped and compared 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_core_en_sequencer;

    localparam logic [2:0] S_OFF = 3'd0;
    localparam logic [2:0] S_PU  = 3'd1;
    localparam logic [2:0] S_RUN = 3'd2;
    localparam logic [2:0] S_QU  = 3'd3;
    localparam logic [2:0] S_DR  = 3'd4;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int TO_CYC  = 8;
    localparam int QU_WAIT = 4;
`else
    localparam int TO_CYC  = 1024;
    localparam int QU_WAIT = 9;
`endif

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i;
    logic       stop_i;
    logic       core_rst_n_fb_i;
    logic       quiesce_ack_i;
    logic       core_en_o;
    logic       quiesce_req_o;
    logic       running_o;
    logic       busy_o;
    logic       err_timeout_o;
    logic [2:0] state_o;

    core_en_sequencer #(
        .CNT_W          (16),
        .OFF_MIN_CYCLES (16),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .core_rst_n_fb_i (core_rst_n_fb_i),
        .quiesce_ack_i   (quiesce_ack_i),
        .core_en_o       (core_en_o),
        .quiesce_req_o   (quiesce_req_o),
        .running_o       (running_o),
        .busy_o          (busy_o),
        .err_timeout_o   (err_timeout_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       start;
        logic       stop;
        logic       fb;
        logic       ack;
        int         reps;
        logic [2:0] st;
        logic       en;
        logic       q;
        logic       err;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step_no  = 0;

    // Expected output vector {state, en, qreq, running, busy, err}.
    function automatic logic [7:0] exp_vec(input logic [2:0] st, input logic en,
                                           input logic q, input logic err);
        logic run_b;
        logic busy_b;
        run_b  = (st == S_RUN);
        busy_b = (st == S_PU) || (st == S_QU) || (st == S_DR);
        return {st, en, q, run_b, busy_b, err};
    endfunction

    function automatic logic [7:0] act_vec();
        return {state_o, core_en_o, quiesce_req_o, running_o, busy_o, err_timeout_o};
    endfunction

    task automatic add(input logic s, input logic t, input logic f, input logic a,
                       input int reps, input logic [2:0] st, input logic en,
                       input logic q, input logic err);
        vec_t v;
        v.start = s; v.stop = t; v.fb = f; v.ack = a; v.reps = reps;
        v.st = st; v.en = en; v.q = q; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check_now(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = act_vec();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got st/en/q/run/busy/err=%b expected %b",
                     name, step_no, act, exp);
        end
    endtask

    task automatic step(input string name, input logic s, input logic t, input logic f,
                        input logic a, input logic [2:0] st, input logic en,
                        input logic q, input logic err);
        start_i         = s;
        stop_i          = t;
        core_rst_n_fb_i = f;
        quiesce_ack_i   = a;
        sb_q.push_back(exp_vec(st, en, q, err));
        @(posedge clk_i);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_now(name, sb_q.pop_front());
        end
    endtask

    initial begin
        reset_n_i       = 1'b0;
        start_i         = 1'b0;
        stop_i          = 1'b0;
        core_rst_n_fb_i = 1'b0;
        quiesce_ack_i   = 1'b0;
        #12;
        check_now("reset_state", 8'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Power-up, run, orderly quiesce and drain, then OFF-state corner cases.
        add(1'b0, 1'b0, 1'b0, 1'b0, 2,       S_OFF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1,       S_PU,  1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4,       S_PU,  1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2,       S_PU,  1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1,       S_RUN, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2,       S_RUN, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1,       S_QU,  1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, QU_WAIT, S_QU,  1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1,       S_DR,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2,       S_DR,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 13,      S_DR,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1,       S_OFF, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 2,       S_OFF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1,       S_OFF, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1,       S_OFF, 1'b0, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step($sformatf("tbl%0d", i), tbl[i].start, tbl[i].stop, tbl[i].fb,
                     tbl[i].ack, tbl[i].st, tbl[i].en, tbl[i].q, tbl[i].err);
            end
        end

        // Unexpected loss of reset release in RUN; a start during DRAIN is dropped.
        step("fbloss_up", 1'b1, 1'b0, 1'b1, 1'b0, S_PU,  1'b1, 1'b0, 1'b0);
        step("fbloss_up", 1'b0, 1'b0, 1'b1, 1'b0, S_PU,  1'b1, 1'b0, 1'b0);
        step("fbloss_up", 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 1'b1, 1'b0, 1'b0);
        step("fbloss_up", 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 1'b1, 1'b0, 1'b0);
        step("fbloss",    1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 1'b1, 1'b0, 1'b0);
        step("fbloss",    1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 1'b1, 1'b0, 1'b0);
        step("fbloss",    1'b0, 1'b0, 1'b0, 1'b0, S_DR,  1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step("drain_start_ign", (k == 1) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0,
                 S_DR, 1'b0, 1'b0, 1'b0);
        end
        step("drain_exit", 1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b0);
        step("no_queue",   1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b0);

        // Stop in POWERUP goes straight to DRAIN; DRAIN holds while feedback stays high.
        step("pu_stop", 1'b1, 1'b0, 1'b1, 1'b0, S_PU, 1'b1, 1'b0, 1'b0);
        step("pu_stop", 1'b0, 1'b1, 1'b1, 1'b0, S_DR, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step("drain_fb_hold", 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b1, 1'b0,
                 S_DR, 1'b0, 1'b0, 1'b0);
        end
        step("drain_fb_low", 1'b0, 1'b0, 1'b0, 1'b0, S_DR,  1'b0, 1'b0, 1'b0);
        step("drain_fb_low", 1'b0, 1'b0, 1'b0, 1'b0, S_DR,  1'b0, 1'b0, 1'b0);
        step("drain_fb_low", 1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in QUIESCE.
        step("rst_q", 1'b1, 1'b0, 1'b1, 1'b0, S_PU,  1'b1, 1'b0, 1'b0);
        step("rst_q", 1'b0, 1'b0, 1'b1, 1'b0, S_PU,  1'b1, 1'b0, 1'b0);
        step("rst_q", 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 1'b1, 1'b0, 1'b0);
        step("rst_q", 1'b0, 1'b1, 1'b1, 1'b0, S_QU,  1'b1, 1'b1, 1'b0);
        step("rst_q", 1'b0, 1'b0, 1'b1, 1'b0, S_QU,  1'b1, 1'b1, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_now("async_reset", 8'd0);
        @(posedge clk_i);
        #1;
        core_rst_n_fb_i = 1'b0;
        reset_n_i       = 1'b1;
        step("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b0);

        // Feedback never rises: watchdog expiry, or an indefinite POWERUP wait.
        step("pu_wait", 1'b1, 1'b0, 1'b0, 1'b0, S_PU, 1'b1, 1'b0, 1'b0);
`ifdef CORE_SEQ_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            step("pu_wait", 1'b0, 1'b0, 1'b0, 1'b0, S_PU, 1'b1, 1'b0, 1'b0);
        end
        step("timeout", 1'b0, 1'b0, 1'b0, 1'b0, S_DR, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            step("timeout_drain", 1'b0, 1'b0, 1'b0, 1'b0, S_DR, 1'b0, 1'b0, 1'b1);
        end
        step("err_sticky", 1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b1);
        step("err_sticky", 1'b1, 1'b1, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b1);
        step("err_clear",  1'b1, 1'b0, 1'b0, 1'b0, S_PU,  1'b1, 1'b0, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            step("pu_wait", 1'b0, 1'b0, 1'b0, 1'b0, S_PU, 1'b1, 1'b0, 1'b0);
        end
`endif
        step("final_stop", 1'b0, 1'b1, 1'b0, 1'b0, S_DR, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step("final_drain", 1'b0, 1'b0, 1'b0, 1'b0, S_DR, 1'b0, 1'b0, 1'b0);
        end
        step("final_off", 1'b0, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
